// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential integer square root, restoring digit-by-digit method.
// Produces one root bit per clock; Root/Remainder are valid while Ack=1.
// Optional build macro ISQRT_ROUND_EN adds a ROUND state so that Root is
// round-half-up(sqrt(Operand)), saturated at all-ones. This adds one cycle of latency.
module isqrt_seq #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Operand,
  output logic [WIDTH/2-1:0] Root,
  output logic [WIDTH/2:0]   Remainder,
  output logic               Busy,
  output logic               Ack
);

  localparam int RW = WIDTH / 2;
  localparam int CW = $clog2(RW + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ROUND = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [RW+1:0]    rem_q, rem_d;
  logic [RW-1:0]    root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    root_out_q, root_out_d;
  logic [RW:0]      rem_out_q, rem_out_d;
  logic [RW+1:0]    rem_sh;
  logic [RW+1:0]    trial;

`ifdef ISQRT_ROUND_EN
  // Round half up: sqrt(N) >= root + 0.5 exactly when rem > root; hold at all-ones.
  function automatic logic [RW-1:0] round_root(input logic [RW-1:0] r,
                                               input logic [RW+1:0] m);
    if ((m > {2'b00, r}) && (r != '1)) return r + 1'b1;
    return r;
  endfunction
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: Start is accepted only in IDLE or DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (Start) state_d = S_RUN;
      S_RUN: begin
        if (cnt_q == CW'(1)) begin
`ifdef ISQRT_ROUND_EN
          state_d = S_ROUND;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ISQRT_ROUND_EN
      S_ROUND: state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    Busy = (state_q == S_RUN) || (state_q == S_ROUND);
    Ack  = (state_q == S_DONE);
  end

  // Datapath next values: operand capture, one root bit per RUN cycle, result latch
  always_comb begin
    op_d       = op_q;
    rem_d      = rem_q;
    root_d     = root_q;
    cnt_d      = cnt_q;
    root_out_d = root_out_q;
    rem_out_d  = rem_out_q;
    rem_sh     = (rem_q << 2) | {{RW{1'b0}}, op_q[WIDTH-1:WIDTH-2]};
    trial      = {root_q, 2'b01};
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          op_d   = Operand;
          rem_d  = '0;
          root_d = '0;
          cnt_d  = CW'(RW);
        end
      end
      S_RUN: begin
        op_d  = {op_q[WIDTH-3:0], 2'b00};
        cnt_d = cnt_q - 1'b1;
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[RW-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[RW-2:0], 1'b0};
        end
`ifndef ISQRT_ROUND_EN
        if (cnt_q == CW'(1)) begin
          root_out_d = root_d;
          rem_out_d  = rem_d[RW:0];
        end
`endif
      end
`ifdef ISQRT_ROUND_EN
      S_ROUND: begin
        root_out_d = round_root(root_q, rem_q);
        rem_out_d  = rem_q[RW:0];
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q       <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      root_out_q <= '0;
      rem_out_q  <= '0;
    end else begin
      op_q       <= op_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      cnt_q      <= cnt_d;
      root_out_q <= root_out_d;
      rem_out_q  <= rem_out_d;
    end
  end

  assign Root      = root_out_q;
  assign Remainder = rem_out_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq: directed steps plus random operands for WIDTH=16 and 32,
// checked against an arithmetic square-root reference model.
module tb_isqrt_seq;

`ifdef ISQRT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int LAT16 = 8 + RND;
  localparam int LAT32 = 16 + RND;

  logic        Clk;
  logic        Reset;
  logic        st16, st32;
  logic [15:0] op16;
  logic [31:0] op32;
  logic [7:0]  root16;
  logic [8:0]  rem16;
  logic [15:0] root32;
  logic [16:0] rem32;
  logic        busy16, ack16, busy32, ack32;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] prev_root, prev_rem;

  isqrt_seq #(.WIDTH(16)) u16 (
    .Clk(Clk), .Reset(Reset), .Start(st16), .Operand(op16),
    .Root(root16), .Remainder(rem16), .Busy(busy16), .Ack(ack16)
  );

  isqrt_seq #(.WIDTH(32)) u32 (
    .Clk(Clk), .Reset(Reset), .Start(st32), .Operand(op32),
    .Root(root32), .Remainder(rem32), .Busy(busy32), .Ack(ack32)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Floor square root by binary search over plain integer arithmetic
  function automatic longint fsqrt(input longint n);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Expected Root: floor, or round-half-up ((r+1/2)^2 <= n) saturated when rounding is built in
  function automatic longint exp_root(input longint n, input int rw);
    longint r;
    r = fsqrt(n);
    if (RND == 1 && (2 * r + 1) * (2 * r + 1) <= 4 * n && r < (64'd1 << rw) - 1) r = r + 1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] g_root(input bit w32);
    return w32 ? 64'(root32) : 64'(root16);
  endfunction
  function automatic logic [63:0] g_rem(input bit w32);
    return w32 ? 64'(rem32) : 64'(rem16);
  endfunction
  function automatic logic g_busy(input bit w32);
    return w32 ? busy32 : busy16;
  endfunction
  function automatic logic g_ack(input bit w32);
    return w32 ? ack32 : ack16;
  endfunction

  // Pulse Start for one edge (edge k); returns #1 after edge k
  task automatic launch(input bit w32, input logic [31:0] op);
    prev_root = g_root(w32);
    prev_rem  = g_rem(w32);
    if (w32) begin op32 = op; st32 = 1'b1; end
    else begin op16 = op[15:0]; st16 = 1'b1; end
    @(posedge Clk); #1;
    st16 = 1'b0;
    st32 = 1'b0;
  endtask

  // From cyc edges after k, check the busy window then the completed result
  task automatic collect(input bit w32, input logic [31:0] op, input string tag, input int cyc);
    int lat, bad;
    longint r, rm;
    lat = w32 ? LAT32 : LAT16;
    bad = 0;
    for (int i = cyc; i < lat; i++) begin
      if (g_busy(w32) !== 1'b1 || g_ack(w32) !== 1'b0 ||
          g_root(w32) !== prev_root || g_rem(w32) !== prev_rem) bad++;
      @(posedge Clk); #1;
    end
    r  = fsqrt(longint'(op));
    rm = longint'(op) - r * r;
    chk({tag, "_window"}, 64'(bad), 64'd0);
    chk({tag, "_ack"}, {63'd0, g_ack(w32)}, 64'd1);
    chk({tag, "_busy"}, {63'd0, g_busy(w32)}, 64'd0);
    chk({tag, "_root"}, g_root(w32), 64'(exp_root(longint'(op), w32 ? 16 : 8)));
    chk({tag, "_rem"}, g_rem(w32), 64'(rm));
  endtask

  task automatic run(input bit w32, input logic [31:0] op, input string tag);
    launch(w32, op);
    collect(w32, op, tag, 0);
  endtask

  initial begin
    int acks;
    logic [31:0] rv;
    Reset = 1'b1;
    st16 = 1'b0;
    st32 = 1'b0;
    op16 = '0;
    op32 = '0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_busy16", {63'd0, busy16}, 64'd0);
    chk("rst_ack16", {63'd0, ack16}, 64'd0);
    chk("rst_root16", 64'(root16), 64'd0);
    chk("rst_rem16", 64'(rem16), 64'd0);
    chk("rst_ack32", {63'd0, ack32}, 64'd0);
    chk("rst_root32", 64'(root32), 64'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Directed 16-bit operands
    run(1'b0, 32'd190, "op190");
    run(1'b0, 32'd65535, "op65535");
    run(1'b0, 32'd16, "op16");
    run(1'b0, 32'd0, "op0");
    run(1'b0, 32'd1, "op1");
    run(1'b0, 32'd2, "op2");

    // Result holds in DONE while idle
    repeat (3) @(posedge Clk);
    #1;
    chk("hold_ack", {63'd0, ack16}, 64'd1);
    chk("hold_root", 64'(root16), 64'(exp_root(2, 8)));

    // Start (and Operand change) during RUN is ignored
    launch(1'b0, 32'd190);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    op16 = 16'd4;
    st16 = 1'b1;
    @(posedge Clk); #1;
    st16 = 1'b0;
    collect(1'b0, 32'd190, "ignore", 3);

    // Restart from DONE
    run(1'b0, 32'd4, "restart4");

    // Reset aborts a running computation
    launch(1'b0, 32'd190);
    repeat (3) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("abort_busy", {63'd0, busy16}, 64'd0);
    chk("abort_ack", {63'd0, ack16}, 64'd0);
    chk("abort_root", 64'(root16), 64'd0);
    chk("abort_rem", 64'(rem16), 64'd0);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (ack16 !== 1'b0 || busy16 !== 1'b0) acks++;
      @(posedge Clk); #1;
    end
    chk("abort_quiet", 64'(acks), 64'd0);
    run(1'b0, 32'd190, "after_abort");

    // 32-bit instance
    run(1'b1, 32'hFFFF_FFFF, "w32_max");
    run(1'b1, 32'h0001_0000, "w32_pow");
    run(1'b1, 32'd0, "w32_zero");

    // Random operands
    for (int i = 0; i < 40; i++) begin
      rv = 32'($urandom_range(0, 65535));
      run(1'b0, rv, "rand16");
    end
    for (int i = 0; i < 12; i++) begin
      rv = $urandom();
      run(1'b1, rv, "rand32");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
